// File: rtl/midi_message_parser_pkg.sv
// Shared types and constants for the MIDI input path.
// Provides the event encoding seen by the voice allocator, the parser state
// encoding, byte classes and the MIDI status/system byte constants.
package midi_message_parser_pkg;

    localparam int unsigned BYTE_WIDTH   = 8;
    localparam int unsigned SYSTEM_CLOCK = 50_000_000;

    typedef enum logic [1:0] {
        NOTE_ON    = 2'd0,
        NOTE_OFF   = 2'd1,
        CONTROL    = 2'd2,
        PITCH_BEND = 2'd3
    } event_t;

    typedef enum logic [1:0] {
        WAIT_STATUS = 2'd0,
        WAIT_DATA1  = 2'd1,
        WAIT_DATA2  = 2'd2,
        SYSEX       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BYTE_DATA     = 2'd0,
        BYTE_CHANNEL  = 2'd1,
        BYTE_COMMON   = 2'd2,
        BYTE_REALTIME = 2'd3
    } byte_class_t;

    // Status nibbles
    localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;
    localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
    localparam logic [3:0] STATUS_CC       = 4'hB;
    localparam logic [3:0] STATUS_PROGRAM  = 4'hC;
    localparam logic [3:0] STATUS_PRESSURE = 4'hD;
    localparam logic [3:0] STATUS_PITCH    = 4'hE;

    // System bytes
    localparam logic [7:0] SYSEX_START  = 8'hF0;
    localparam logic [7:0] SYSEX_END    = 8'hF7;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

endpackage

// File: rtl/midi_message_parser.sv
// MIDI channel-message parser sitting behind the UART receiver.
// Assembles status/data bytes into note on/off, control change and pitch
// bend events, with running status, transparent real-time bytes, SysEx
// discard and a timeout on a stalled second data byte.
//
// Ports:
//   clock_50_000_000  system clock
//   reset_l           asynchronous active-low reset
//   data_in           received byte, valid while data_in_ready=1
//   data_in_ready     one-cycle strobe per received byte
//   omni              1 = accept every channel
//   channel_select    channel accepted when omni=0
//   event_valid       one-cycle strobe for a completed, accepted message
//   event_type        NOTE_ON / NOTE_OFF / CONTROL / PITCH_BEND
//   event_channel     channel nibble of the message status
//   event_data1       note / controller / bend LSB
//   event_data2       velocity / value / bend MSB
module midi_message_parser
    import midi_message_parser_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = SYSTEM_CLOCK / 100
) (
    input  logic                  clock_50_000_000,
    input  logic                  reset_l,
    input  logic [BYTE_WIDTH-1:0] data_in,
    input  logic                  data_in_ready,
    input  logic                  omni,
    input  logic [3:0]            channel_select,
    output logic                  event_valid,
    output event_t                event_type,
    output logic [3:0]            event_channel,
    output logic [6:0]            event_data1,
    output logic [6:0]            event_data2
);

    localparam int unsigned CNT_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    state_t                  state;
    logic [BYTE_WIDTH-1:0]   status;
    logic [6:0]              d1;
    logic [CNT_W-1:0]        tcount;

    byte_class_t             byte_class_c;
    logic                    emit_c;
    event_t                  emit_type_c;
    logic                    one_data_byte_c;

    function automatic byte_class_t classify(input logic [BYTE_WIDTH-1:0] b);
        if (!b[BYTE_WIDTH-1])  return BYTE_DATA;
        if (b < SYSEX_START)   return BYTE_CHANNEL;
        if (b < REALTIME_MIN)  return BYTE_COMMON;
        return BYTE_REALTIME;
    endfunction

    assign byte_class_c    = classify(data_in);
    assign one_data_byte_c = (status[7:4] == STATUS_PROGRAM) || (status[7:4] == STATUS_PRESSURE);

    // Event decode for a message completed by the current data byte.
    always_comb begin
        emit_c      = 1'b1;
        emit_type_c = NOTE_ON;
        case (status[7:4])
            STATUS_NOTE_ON:  emit_type_c = (data_in[6:0] != 7'd0) ? NOTE_ON : NOTE_OFF;
            STATUS_NOTE_OFF: emit_type_c = NOTE_OFF;
            STATUS_CC:       emit_type_c = CONTROL;
            STATUS_PITCH:    emit_type_c = PITCH_BEND;
            default:         emit_c      = 1'b0;
        endcase
        if (!omni && (status[3:0] != channel_select)) begin
            emit_c = 1'b0;
        end
    end

    // Parser FSM with registered event outputs.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state         <= WAIT_STATUS;
            status        <= '0;
            d1            <= '0;
            tcount        <= '0;
            event_valid   <= 1'b0;
            event_type    <= NOTE_ON;
            event_channel <= '0;
            event_data1   <= '0;
            event_data2   <= '0;
        end else begin
            event_valid <= 1'b0;
            if (data_in_ready) begin
                case (byte_class_c)
                    BYTE_REALTIME: begin
                        // transparent: nothing changes, timeout counter frozen
                    end
                    BYTE_CHANNEL: begin
                        status <= data_in;
                        state  <= WAIT_DATA1;
                    end
                    BYTE_COMMON: begin
                        status <= '0;
                        state  <= (data_in == SYSEX_START) ? SYSEX : WAIT_STATUS;
                    end
                    default: begin
                        case (state)
                            WAIT_DATA1: begin
                                if (!one_data_byte_c) begin
                                    d1     <= data_in[6:0];
                                    tcount <= '0;
                                    state  <= WAIT_DATA2;
                                end
                            end
                            WAIT_DATA2: begin
                                state <= WAIT_DATA1;
                                if (emit_c) begin
                                    event_valid   <= 1'b1;
                                    event_type    <= emit_type_c;
                                    event_channel <= status[3:0];
                                    event_data1   <= d1;
                                    event_data2   <= data_in[6:0];
                                end
                            end
                            default: begin
                                // no running status or inside SysEx: discard
                            end
                        endcase
                    end
                endcase
            end else if (state == WAIT_DATA2) begin
                // A byte in the expiry cycle takes the branch above, so it wins.
                if (tcount == CNT_LAST) begin
                    state <= WAIT_DATA1;
                end else begin
                    tcount <= tcount + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_message_parser.sv
// Self-checking bench for midi_message_parser: directed scenarios plus
// randomized byte streams compared against a message-level reference model.
module tb_midi_message_parser;
    import midi_message_parser_pkg::*;

    localparam int unsigned T = 16;

    logic       clk = 1'b0;
    logic       rst_l;
    logic [7:0] data_in;
    logic       data_in_ready;
    logic       omni;
    logic [3:0] channel_select;
    logic       event_valid;
    event_t     event_type;
    logic [3:0] event_channel;
    logic [6:0] event_data1;
    logic [6:0] event_data2;

    always #10 clk = ~clk;

    midi_message_parser #(.TIMEOUT_TICKS(T)) dut (
        .clock_50_000_000 (clk),
        .reset_l          (rst_l),
        .data_in          (data_in),
        .data_in_ready    (data_in_ready),
        .omni             (omni),
        .channel_select   (channel_select),
        .event_valid      (event_valid),
        .event_type       (event_type),
        .event_channel    (event_channel),
        .event_data1      (event_data1),
        .event_data2      (event_data2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: running status byte (-1 = none), pending data bytes,
    // and cycles waited for the second data byte.
    int          rs;
    int unsigned msg[$];
    int          age;
    bit          exp_valid;
    int unsigned exp_type, exp_ch, exp_d1, exp_d2;
    int          events_seen;
    int          events_mark;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        rs = -1;
        msg.delete();
        age = 0;
        exp_valid = 1'b0;
        exp_type = 0; exp_ch = 0; exp_d1 = 0; exp_d2 = 0;
    endfunction

    function automatic void deliver(int hi, int ch, int a, int b, bit om, int sel);
        int unsigned t;
        if (!om && ch != sel) return;
        case (hi)
            9:       t = (b != 0) ? 32'(NOTE_ON) : 32'(NOTE_OFF);
            8:       t = 32'(NOTE_OFF);
            11:      t = 32'(CONTROL);
            14:      t = 32'(PITCH_BEND);
            default: return;
        endcase
        exp_valid = 1'b1;
        exp_type = t; exp_ch = ch; exp_d1 = a; exp_d2 = b;
    endfunction

    function automatic void model_step(bit rdy, int b, bit om, int sel);
        int hi;
        int need;
        exp_valid = 1'b0;
        if (rdy) begin
            if (b >= 'hF8) begin
                // real-time: invisible
            end else if (b >= 'h80 && b < 'hF0) begin
                rs = b;
                msg.delete();
            end else if (b >= 'hF0) begin
                rs = -1;
                msg.delete();
            end else if (rs >= 0) begin
                hi   = rs >> 4;
                need = (hi == 12 || hi == 13) ? 1 : 2;
                msg.push_back(b);
                if (msg.size() == 1) age = 0;
                if (msg.size() == need) begin
                    if (need == 2) deliver(hi, rs & 15, msg[0], msg[1], om, sel);
                    msg.delete();
                end
            end
        end else if (msg.size() == 1) begin
            if (age == T - 1) msg.delete();
            else age++;
        end
    endfunction

    task automatic compare_outputs(input string tag);
        check({tag, "_valid"}, 32'(event_valid), 32'(exp_valid));
        check({tag, "_type"},  32'(event_type),  exp_type);
        check({tag, "_ch"},    32'(event_channel), exp_ch);
        check({tag, "_d1"},    32'(event_data1), exp_d1);
        check({tag, "_d2"},    32'(event_data2), exp_d2);
        if (event_valid) events_seen++;
    endtask

    task automatic step(input bit rdy, input logic [7:0] b);
        data_in_ready = rdy;
        data_in       = rdy ? b : 8'($urandom);
        @(posedge clk);
        model_step(rdy, int'(b), omni, int'(channel_select));
        @(negedge clk);
        data_in_ready = 1'b0;
        compare_outputs("cyc");
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic expect_events(input string tag, input int n);
        check(tag, 32'(events_seen - events_mark), 32'(n));
        events_mark = events_seen;
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        compare_outputs("reset");
        rst_l = 1'b1;
    endtask

    initial begin
        rst_l = 1'b0;
        data_in = 8'h00;
        data_in_ready = 1'b0;
        omni = 1'b1;
        channel_select = 4'd0;
        events_seen = 0;
        events_mark = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        idle(2);

        // Basic note on
        send(8'h93); send(8'h3C); send(8'h64);
        expect_events("t1_count", 1);
        check("t1_type", 32'(event_type), 32'(NOTE_ON));
        check("t1_ch", 32'(event_channel), 32'h3);
        check("t1_d1", 32'(event_data1), 32'h3C);
        check("t1_d2", 32'(event_data2), 32'h64);
        idle(3);

        // Running status, velocity zero becomes note off
        send(8'h90); send(8'h40); send(8'h7F); send(8'h40); send(8'h00);
        expect_events("t2_count", 2);
        check("t2_type", 32'(event_type), 32'(NOTE_OFF));
        idle(2);

        // Real-time byte between data bytes
        send(8'h90); send(8'h40); send(8'hF8); send(8'h7F);
        expect_events("t3_count", 1);
        check("t3_d2", 32'(event_data2), 32'h7F);
        idle(2);

        // SysEx clears running status
        send(8'hF0); send(8'h12); send(8'h34); send(8'hF7); send(8'h40); send(8'h7F);
        expect_events("t4_count", 0);
        idle(2);

        // Stalled pitch bend times out
        send(8'hE0); send(8'h00); idle(T + 2); send(8'h40); send(8'h00);
        expect_events("t5_count", 1);
        check("t5_type", 32'(event_type), 32'(PITCH_BEND));
        check("t5_d1", 32'(event_data1), 32'h40);
        check("t5_d2", 32'(event_data2), 32'h00);

        // Byte in the expiry cycle wins
        send(8'hE1); send(8'h10); idle(T - 1); send(8'h20);
        expect_events("t5b_count", 1);
        check("t5b_d1", 32'(event_data1), 32'h10);
        // One cycle later it has expired; 0x20 becomes the new d1
        send(8'h10); idle(T); send(8'h20);
        expect_events("t5c_count", 0);
        send(8'h30);
        expect_events("t5d_count", 1);
        check("t5d_d1", 32'(event_data1), 32'h20);
        idle(2);

        // Channel filter
        omni = 1'b0; channel_select = 4'd2;
        send(8'hB5); send(8'h07); send(8'h64); send(8'hB2); send(8'h07); send(8'h64);
        expect_events("t6_count", 1);
        check("t6_ch", 32'(event_channel), 32'h2);
        check("t6_type", 32'(event_type), 32'(CONTROL));
        omni = 1'b1;
        idle(2);

        // Reset drops the partial message and running status
        send(8'h90);
        do_reset();
        send(8'h3C); send(8'h64);
        expect_events("t7_count", 0);
        idle(2);

        // Randomized streams
        for (int i = 0; i < 6000; i++) begin
            int r;
            logic [7:0] b;
            if ($urandom_range(0, 49) == 0) begin
                omni = 1'($urandom);
                channel_select = 4'($urandom_range(0, 3));
            end
            r = int'($urandom_range(0, 99));
            if (r < 50)      b = 8'($urandom_range(0, 8'h7F));
            else if (r < 55) b = 8'h00;
            else if (r < 75) b = 8'($urandom_range(8'h80, 8'hEF)) & 8'hF3;
            else if (r < 82) b = 8'($urandom_range(8'hF8, 8'hFF));
            else if (r < 85) b = SYSEX_START;
            else if (r < 88) b = SYSEX_END;
            else             b = 8'($urandom_range(8'hF1, 8'hF6));
            if ($urandom_range(0, 2) == 0) step(1'b0, 8'h00);
            if ($urandom_range(0, 199) == 0) idle(int'($urandom_range(T - 2, T + 1)));
            step(1'b1, b);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
